// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
//
// Multi-cycle integer ALU for the RV32I datapath. Executes one operation per
// start/ready handshake. The 4-bit code is {funct7[5], funct3} from the ALU
// control decoder.
//
// Add/sub/logic/compare complete in one cycle. Shifts run one bit per cycle.
// Undefined codes complete in one cycle and raise the illegal flag.
//
// Handshake: an operation is accepted on a rising clk edge where
// start && ready. Code and operands are latched at that edge, and later input
// changes are ignored. A start seen while ready=0 is dropped, not queued.
// done pulses for one cycle. result/zero/illegal are written on entry to
// DONE and hold until the next operation reaches DONE.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted only while ready=1
//   ready       out  high in IDLE
//   alu_contrl  in   [3:0] operation code, sampled on accept
//   op_a        in   [XLEN-1:0] operand A, sampled on accept
//   op_b        in   [XLEN-1:0] operand B, sampled on accept; [4:0] = shamt
//   busy        out  high in SHIFT and DONE
//   done        out  one-cycle completion pulse
//   result      out  [XLEN-1:0] registered result
//   zero        out  registered (result == 0)
//   illegal     out  registered undefined-code flag
// -----------------------------------------------------------------------------
module alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ready,
  input  logic [3:0]      alu_contrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SLL  = 4'b0001;
  localparam logic [3:0] C_SLT  = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_OR   = 4'b0110;
  localparam logic [3:0] C_AND  = 4'b0111;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      code_q;
  logic [XLEN-1:0] shreg;
  logic [XLEN-1:0] shreg_next;
  logic [4:0]      count;

  logic            accept;
  logic            is_shift;
  logic            go_shift;
  logic [4:0]      amt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  assign ready    = (state == S_IDLE);
  assign busy     = (state == S_SHIFT) || (state == S_DONE);
  assign done     = (state == S_DONE);
  assign accept   = start && ready;
  assign amt      = op_b[4:0];
  assign is_shift = (alu_contrl == C_SLL) || (alu_contrl == C_SRL) ||
                    (alu_contrl == C_SRA);
  // A shift by zero takes the single-cycle path and returns op_a.
  assign go_shift = is_shift && (amt != 5'd0);

  // Single-cycle results, evaluated on the live inputs at accept.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_contrl)
      C_ADD:  alu_res = op_a + op_b;
      C_SUB:  alu_res = op_a - op_b;
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      C_XOR:  alu_res = op_a ^ op_b;
      C_OR:   alu_res = op_a | op_b;
      C_AND:  alu_res = op_a & op_b;
      C_SLL, C_SRL, C_SRA: alu_res = op_a;
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // One-bit step of the iterative shifter, direction from the latched code.
  always_comb begin
    shreg_next = shreg;
    case (code_q)
      C_SLL:   shreg_next = {shreg[XLEN-2:0], 1'b0};
      C_SRL:   shreg_next = {1'b0, shreg[XLEN-1:1]};
      C_SRA:   shreg_next = {shreg[XLEN-1], shreg[XLEN-1:1]};
      default: shreg_next = shreg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = go_shift ? S_SHIFT : S_DONE;
      end
      // count <= 1 rather than == 1 so a corrupted count cannot trap the FSM.
      S_SHIFT: begin
        if (count <= 5'd1) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      shreg   <= '0;
      count   <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            code_q <= alu_contrl;
            shreg  <= op_a;
            count  <= amt;
            if (!go_shift) begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              illegal <= alu_ill;
            end
          end
        end
        S_SHIFT: begin
          shreg <= shreg_next;
          count <= count - 5'd1;
          if (count <= 5'd1) begin
            result  <= shreg_next;
            zero    <= (shreg_next == '0);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter
//
// Directed bench for alu_iter. A table of {code, operands, latency, expected
// result/zero/illegal} records runs through one driver task. Hand-written
// sequences cover reset values, a dropped start while busy, and reset
// asserted in the middle of a shift.
// -----------------------------------------------------------------------------
module tb_alu_iter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            ready;
  logic [3:0]      alu_contrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int errors = 0;
  int checks = 0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .alu_contrl (alu_contrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one op at a negedge. It is accepted at the next posedge (T).
  // The task then scrambles the inputs and waits for done. A done seen at the
  // k-th negedge after T means latency k.
  task automatic run_op(input string name, input logic [3:0] code,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ill);
    int c;
    bit got;
    @(negedge clk);
    check({name, "_ready_in"}, {31'd0, ready}, 32'd1);
    alu_contrl = code;
    op_a       = a;
    op_b       = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    alu_contrl = 4'($urandom_range(0, 15));
    op_a       = $urandom;
    op_b       = $urandom;
    c   = 0;
    got = 1'b0;
    while (c < 40 && !got) begin
      @(negedge clk);
      c++;
      if (done) got = 1'b1;
    end
    check({name, "_latency"}, 32'(c), 32'(lat));
    check({name, "_result"}, result, exp_res);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    check({name, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    @(negedge clk);
    check({name, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({name, "_ready_out"}, {31'd0, ready}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    alu_contrl = '0;
    op_a       = '0;
    op_b       = '0;

    vecs[0]  = '{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{"sub_eq",    4'b1000, 32'h0000_1234, 32'h0000_1234, 1,  32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{"sub_ne",    4'b1000, 32'h0000_0005, 32'h0000_0003, 1,  32'h0000_0002, 1'b0, 1'b0};
    vecs[3]  = '{"slt",       4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0001, 1'b0, 1'b0};
    vecs[4]  = '{"sltu",      4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{"xor",       4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1,  32'hFF00_FF00, 1'b0, 1'b0};
    vecs[6]  = '{"or",        4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1,  32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[7]  = '{"sra_neg",   4'b1101, 32'h8000_0000, 32'h0000_0004, 5,  32'hF800_0000, 1'b0, 1'b0};
    vecs[8]  = '{"sra_pos",   4'b1101, 32'h7FFF_FFF0, 32'h0000_0004, 5,  32'h07FF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{"srl",       4'b0101, 32'h8000_0000, 32'h0000_0004, 5,  32'h0800_0000, 1'b0, 1'b0};
    vecs[10] = '{"sll_31",    4'b0001, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{"srl_by0",   4'b0101, 32'hDEAD_BEEF, 32'h0000_0020, 1,  32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[12] = '{"ill_1010",  4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 1,  32'h0000_0000, 1'b1, 1'b1};
    vecs[13] = '{"and_clr",   4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1,  32'h00F0_00F0, 1'b0, 1'b0};
    vecs[14] = '{"ill_1111",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'h0000_0000, 1'b1, 1'b1};

    // ---- reset values ----
    #23;
    check("rst_ready",   {31'd0, ready},   32'd1);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_result",  result,           32'd0);
    check("rst_zero",    {31'd0, zero},    32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].res, vecs[i].z, vecs[i].ill);

    // ---- SRA with a start pulse while busy (must be dropped) ----
    run_op("pre_add", 4'b0000, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    alu_contrl = 4'b1101;
    op_a       = 32'h8000_0000;
    op_b       = 32'h0000_0004;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("sra_busy_c%0d", k), {31'd0, busy}, 32'd1);
      check($sformatf("sra_done_c%0d", k), {31'd0, done}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 1) check("sra_hold_at_accept", result, 32'd5);
      if (k == 2) begin
        alu_contrl = 4'b0000;
        op_a       = 32'd1;
        op_b       = 32'd1;
        start      = 1'b1;
      end
      if (k == 3) start = 1'b0;
    end
    check("sra_busy_result", result, 32'hF800_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sra_no_extra_done%0d", k), {31'd0, done}, 32'd0);
      check($sformatf("sra_result_hold%0d", k), result, 32'hF800_0000);
    end

    // ---- reset in the middle of SLL by 20 ----
    @(negedge clk);
    alu_contrl = 4'b0001;
    op_a       = 32'h0000_0001;
    op_b       = 32'd20;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready",   {31'd0, ready},   32'd1);
    check("midrst_done",    {31'd0, done},    32'd0);
    check("midrst_busy",    {31'd0, busy},    32'd0);
    check("midrst_result",  result,           32'd0);
    check("midrst_zero",    {31'd0, zero},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);
    end
    check("midrst_result_after", result, 32'd0);
    check("midrst_ready_after", {31'd0, ready}, 32'd1);

    // ---- normal op after the aborted one ----
    run_op("post_rst_sll", 4'b0001, 32'h0000_0003, 32'h0000_0002, 3,
           32'h0000_000C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
